// File: rtl/scan_unload_ctrl.sv
// Scan unload: captures a parallel snapshot and shifts it out one bit per handshake.
// Optional even-parity trailer bit when SCAN_UNLOAD_PARITY_EN is defined.
module scan_unload_ctrl #(
  parameter int WIDTH     = 16,
  parameter int CNT_W     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             cap_valid,
  output logic             cap_ready,
  input  logic [WIDTH-1:0] cap_data,
  output logic             so,
  output logic             so_valid,
  input  logic             so_ready,
  output logic             so_last,
  output logic             busy
);

`ifdef SCAN_UNLOAD_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [FRAME-1:0] sr;
  logic [FRAME-1:0] sr_nx;
  logic [FRAME-1:0] frame_in;
  logic [FRAME-1:0] sr_shift;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             head;

  // Frame image and one-step shift; the parity bit sits just past the tail
  always_comb begin
    frame_in = '0;
    sr_shift = '0;
    head     = 1'b0;
    if (MSB_FIRST != 0) begin
`ifdef SCAN_UNLOAD_PARITY_EN
      frame_in = {cap_data, ^cap_data};
`else
      frame_in = cap_data;
`endif
      sr_shift = {sr[FRAME-2:0], 1'b0};
      head     = sr[FRAME-1];
    end else begin
`ifdef SCAN_UNLOAD_PARITY_EN
      frame_in = {^cap_data, cap_data};
`else
      frame_in = cap_data;
`endif
      sr_shift = {1'b0, sr[FRAME-1:1]};
      head     = sr[0];
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nx  = state;
    sr_nx     = sr;
    cnt_nx    = cnt;
    cap_ready = 1'b0;
    so_valid  = 1'b0;
    so        = 1'b0;
    so_last   = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        cap_ready = 1'b1;
        if (cap_valid) begin
          sr_nx    = frame_in;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        so_valid = 1'b1;
        so       = head;
        so_last  = (cnt == LAST);
        if (so_ready) begin
          sr_nx = sr_shift;
          if (cnt == LAST) begin
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, shift register and bit counter
  always_ff @(posedge clk) begin
    if (!rn) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule
